spi_txn_arbiter: RTL and testbench

SPI_TXN_ARBITER -- requirements
Module: spi_txn_arbiter

---
 rtl/spi_arb_pkg.sv | 20 ++
 rtl/spi_rr_arbiter.sv | 37 +++
 rtl/spi_txn_arbiter.sv | 154 +++++++++++++++
 tb/tb_spi_txn_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// rtl/spi_arb_pkg.sv - shared types and constants for the SPI transaction arbiter
//
// Contents:
//   arb_state_t    : transaction FSM states (IDLE, START, WAIT, DONE)
//   SPI_BYTE_W     : width of one SPI transfer byte
//   SPI_ABORT_BYTE : byte returned to the requester when a transfer is aborted
package spi_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    localparam int SPI_BYTE_W = 8;

    localparam logic [SPI_BYTE_W-1:0] SPI_ABORT_BYTE = 8'hFF;

endpackage

// File: rtl/spi_rr_arbiter.sv
// rtl/spi_rr_arbiter.sv - combinational round-robin winner select
//
// Ports:
//   req   [NUM_REQ-1:0] : active requests
//   ptr   [PW-1:0]      : index with highest priority this round
//   grant [NUM_REQ-1:0] : one-hot winner, zero when no request is active
module spi_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic found;

    // Two passes instead of a modulo rotation: first look from ptr upward,
    // then wrap around to the requesters below ptr.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req[j] && (j >= int'(ptr))) begin
                grant[j] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req[j] && (j < int'(ptr))) begin
                grant[j] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_txn_arbiter.sv
// rtl/spi_txn_arbiter.sv - round-robin arbiter sharing one SPI master among requesters
//
// Optional feature: define SPI_ARB_TIMEOUT_EN to abort a transfer after
// TIMEOUT_CYCLES cycles in WAIT without m_done (rx_byte=8'hFF, timeout_err=1).
//
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   req, tx_byte         : per-requester request level and byte to send
//   gnt, done            : one-hot grant / completion pulses
//   rx_byte, timeout_err : received byte and abort flag, valid with done
//   busy                 : high whenever the FSM is not IDLE
//   m_start, m_tx_byte   : start pulse and byte towards the SPI master
//   m_cs_n               : per-slave active-low chip selects
//   m_done, m_rx_byte    : completion pulse and received byte from the SPI master
module spi_txn_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [SPI_BYTE_W*NUM_REQ-1:0] tx_byte,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            done,
    output logic [SPI_BYTE_W-1:0]         rx_byte,
    output logic                          timeout_err,
    output logic                          busy,
    output logic                          m_start,
    output logic [SPI_BYTE_W-1:0]         m_tx_byte,
    output logic [NUM_REQ-1:0]            m_cs_n,
    input  logic                          m_done,
    input  logic [SPI_BYTE_W-1:0]         m_rx_byte
);

    localparam int PW = $clog2(NUM_REQ);

    arb_state_t              state, state_next;
    logic [NUM_REQ-1:0]      win;
    logic [NUM_REQ-1:0]      owner;
    logic [PW-1:0]           ptr;
    logic [PW-1:0]           win_idx;
    logic [SPI_BYTE_W-1:0]   win_byte;
    logic [SPI_BYTE_W-1:0]   tx_q;
    logic [SPI_BYTE_W-1:0]   rx_q;
    logic                    wait_abort;

    spi_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_rr (
        .req     (req),
        .ptr     (ptr),
        .grant   (win)
    );

    always_comb begin
        win_idx  = '0;
        win_byte = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (win[j]) begin
                win_idx  = PW'(j);
                win_byte = tx_byte[j*SPI_BYTE_W +: SPI_BYTE_W];
            end
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    logic [7:0] to_cnt;
    logic       abort_q;

    // m_done is checked first, so a completion arriving in the very cycle the
    // counter expires is treated as a normal transfer.
    assign wait_abort  = !m_done && ((to_cnt + 8'd1) == 8'(TIMEOUT_CYCLES));
    assign timeout_err = (state == ST_DONE) && abort_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt  <= '0;
            abort_q <= 1'b0;
        end else begin
            if (state == ST_START) begin
                to_cnt <= '0;
            end else if (state == ST_WAIT) begin
                to_cnt <= to_cnt + 8'd1;
                if (m_done) begin
                    abort_q <= 1'b0;
                end else if (wait_abort) begin
                    abort_q <= 1'b1;
                end
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^8'(TIMEOUT_CYCLES);
    assign wait_abort         = 1'b0;
    assign timeout_err        = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (|req) state_next = ST_START;
            ST_START: state_next = ST_WAIT;
            ST_WAIT:  if (m_done || wait_abort) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Winner, byte and pointer are all latched on the IDLE decision edge so
    // later req/tx_byte changes cannot disturb the transfer in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner <= '0;
            ptr   <= '0;
            tx_q  <= '0;
            rx_q  <= '0;
        end else begin
            if ((state == ST_IDLE) && (|req)) begin
                owner <= win;
                tx_q  <= win_byte;
                ptr   <= (int'(win_idx) == NUM_REQ-1) ? '0 : win_idx + 1'b1;
            end
            if (state == ST_WAIT) begin
                if (m_done) begin
                    rx_q <= m_rx_byte;
                end else if (wait_abort) begin
                    rx_q <= SPI_ABORT_BYTE;
                end
            end
        end
    end

    assign busy      = (state != ST_IDLE);
    assign m_start   = (state == ST_START);
    assign gnt       = (state == ST_START) ? owner : '0;
    assign done      = (state == ST_DONE) ? owner : '0;
    assign m_cs_n    = ((state == ST_START) || (state == ST_WAIT)) ? ~owner : '1;
    assign m_tx_byte = tx_q;
    assign rx_byte   = rx_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// tb/tb_spi_txn_arbiter.sv - directed self-checking bench for spi_txn_arbiter
module tb_spi_txn_arbiter;

    localparam int TO = 16;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] tx_byte;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [7:0]  rx_byte;
    logic        timeout_err;
    logic        busy;
    logic        m_start;
    logic [7:0]  m_tx_byte;
    logic [3:0]  m_cs_n;
    logic        m_done;
    logic [7:0]  m_rx_byte;

    int checks = 0;
    int errors = 0;

    spi_txn_arbiter #(
        .NUM_REQ        (4),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .tx_byte     (tx_byte),
        .gnt         (gnt),
        .done        (done),
        .rx_byte     (rx_byte),
        .timeout_err (timeout_err),
        .busy        (busy),
        .m_start     (m_start),
        .m_tx_byte   (m_tx_byte),
        .m_cs_n      (m_cs_n),
        .m_done      (m_done),
        .m_rx_byte   (m_rx_byte)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({gnt, done, busy, m_start, timeout_err} !== 11'b0) begin
            errors++;
            $display("FAIL reset_ctl got gnt=%b done=%b busy=%b m_start=%b te=%b want all 0",
                     gnt, done, busy, m_start, timeout_err);
        end
        checks++;
        if ({rx_byte, m_tx_byte} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_bytes got rx=%h mtx=%h want 00 00", rx_byte, m_tx_byte);
        end
        checks++;
        if (m_cs_n !== 4'b1111) begin
            errors++;
            $display("FAIL reset_cs got %b want 1111", m_cs_n);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        req = 4'b0010;
        tick();
        checks++;
        if (gnt !== 4'b0010 || m_start !== 1'b1) begin
            errors++;
            $display("FAIL basic_gnt got gnt=%b m_start=%b want 0010 1", gnt, m_start);
        end
        checks++;
        if (m_tx_byte !== 8'hA5 || m_cs_n !== 4'b1101) begin
            errors++;
            $display("FAIL basic_start got mtx=%h cs=%b want a5 1101", m_tx_byte, m_cs_n);
        end
        req = 4'b0000;
        tick();
        checks++;
        if (gnt !== 4'b0000 || m_start !== 1'b0 || m_cs_n !== 4'b1101 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_wait got gnt=%b ms=%b cs=%b busy=%b want 0000 0 1101 1",
                     gnt, m_start, m_cs_n, busy);
        end
        repeat (9) tick();
        checks++;
        if (done !== 4'b0000 || m_tx_byte !== 8'hA5) begin
            errors++;
            $display("FAIL basic_hold got done=%b mtx=%h want 0000 a5", done, m_tx_byte);
        end
        m_done    = 1'b1;
        m_rx_byte = 8'h3C;
        tick();
        m_done    = 1'b0;
        m_rx_byte = 8'h00;
        checks++;
        if (done !== 4'b0010 || rx_byte !== 8'h3C || m_cs_n !== 4'b1111 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_done got done=%b rx=%h cs=%b te=%b want 0010 3c 1111 0",
                     done, rx_byte, m_cs_n, timeout_err);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 4'b0000) begin
            errors++;
            $display("FAIL basic_idle got busy=%b done=%b want 0 0000", busy, done);
        end
    endtask

    task automatic test_round_robin;
        logic [7:0] exp_tx [4];
        exp_tx[0] = 8'h11;
        exp_tx[1] = 8'hA5;
        exp_tx[2] = 8'h33;
        exp_tx[3] = 8'h44;
        // Fresh reset so the pointer starts at 0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (gnt !== (4'b0001 << i) || m_tx_byte !== exp_tx[i]) begin
                errors++;
                $display("FAIL rr_gnt%0d got gnt=%b mtx=%h want %b %h",
                         i, gnt, m_tx_byte, 4'b0001 << i, exp_tx[i]);
            end
            tick();
            m_done    = 1'b1;
            m_rx_byte = 8'h50 + 8'(i);
            tick();
            m_done = 1'b0;
            checks++;
            if (done !== (4'b0001 << i) || rx_byte !== (8'h50 + 8'(i)) || gnt !== 4'b0000) begin
                errors++;
                $display("FAIL rr_done%0d got done=%b rx=%h gnt=%b want %b %h 0000",
                         i, done, rx_byte, gnt, 4'b0001 << i, 8'h50 + 8'(i));
            end
            if (i == 3) req = 4'b0000;
            tick();
            checks++;
            if (busy !== 1'b0 || gnt !== 4'b0000) begin
                errors++;
                $display("FAIL rr_gap%0d got busy=%b gnt=%b want 0 0000", i, busy, gnt);
            end
        end
    endtask

    task automatic test_pointer_and_withdraw;
        req = 4'b0100;
        tick();
        checks++;
        if (gnt !== 4'b0100) begin
            errors++;
            $display("FAIL ptr_g2 got %b want 0100", gnt);
        end
        req = 4'b0000;
        tick();
        // Requester 1 raises and drops its request entirely inside the transfer.
        req = 4'b1011;
        tick();
        checks++;
        if (m_cs_n !== 4'b1011 || gnt !== 4'b0000 || m_tx_byte !== 8'h33) begin
            errors++;
            $display("FAIL ptr_stable got cs=%b gnt=%b mtx=%h want 1011 0000 33",
                     m_cs_n, gnt, m_tx_byte);
        end
        req       = 4'b1001;
        m_done    = 1'b1;
        m_rx_byte = 8'h77;
        tick();
        m_done = 1'b0;
        checks++;
        if (done !== 4'b0100 || rx_byte !== 8'h77) begin
            errors++;
            $display("FAIL ptr_done2 got done=%b rx=%h want 0100 77", done, rx_byte);
        end
        tick();
        tick();
        checks++;
        if (gnt !== 4'b1000 || m_tx_byte !== 8'h44) begin
            errors++;
            $display("FAIL ptr_g3_first got gnt=%b mtx=%h want 1000 44", gnt, m_tx_byte);
        end
        tick();
        m_done    = 1'b1;
        m_rx_byte = 8'h88;
        tick();
        m_done = 1'b0;
        tick();
        tick();
        checks++;
        if (gnt !== 4'b0001 || m_cs_n !== 4'b1110) begin
            errors++;
            $display("FAIL ptr_g0_next got gnt=%b cs=%b want 0001 1110", gnt, m_cs_n);
        end
        req = 4'b0000;
        tick();
        m_done    = 1'b1;
        m_rx_byte = 8'h99;
        tick();
        m_done = 1'b0;
        checks++;
        if (done !== 4'b0001 || rx_byte !== 8'h99) begin
            errors++;
            $display("FAIL ptr_done0 got done=%b rx=%h want 0001 99", done, rx_byte);
        end
        tick();
    endtask

    task automatic test_mdone_idle;
        req       = 4'b0000;
        m_done    = 1'b1;
        m_rx_byte = 8'h55;
        tick();
        m_done = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 4'b0000 || gnt !== 4'b0000 || rx_byte !== 8'h99) begin
            errors++;
            $display("FAIL idle_mdone got busy=%b done=%b gnt=%b rx=%h want 0 0000 0000 99",
                     busy, done, gnt, rx_byte);
        end
    endtask

    task automatic test_reset_mid_wait;
        req = 4'b0001;
        tick();
        req = 4'b0000;
        tick();
`ifdef SPI_ARB_TIMEOUT_EN
        repeat (5) tick();
`else
        repeat (300) tick();
`endif
        checks++;
        if (busy !== 1'b1 || m_cs_n !== 4'b1110 || timeout_err !== 1'b0 || done !== 4'b0000) begin
            errors++;
            $display("FAIL wait_hold got busy=%b cs=%b te=%b done=%b want 1 1110 0 0000",
                     busy, m_cs_n, timeout_err, done);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (m_cs_n !== 4'b1111 || busy !== 1'b0 || m_tx_byte !== 8'h00 || rx_byte !== 8'h00) begin
            errors++;
            $display("FAIL async_reset got cs=%b busy=%b mtx=%h rx=%h want 1111 0 00 00",
                     m_cs_n, busy, m_tx_byte, rx_byte);
        end
        @(posedge clk);
        #1;
        reset     = 1'b0;
        m_done    = 1'b1;
        m_rx_byte = 8'h12;
        tick();
        m_done = 1'b0;
        tick();
        checks++;
        if (done !== 4'b0000 || busy !== 1'b0 || rx_byte !== 8'h00) begin
            errors++;
            $display("FAIL post_reset got done=%b busy=%b rx=%h want 0000 0 00", done, busy, rx_byte);
        end
    endtask

`ifdef SPI_ARB_TIMEOUT_EN
    task automatic test_timeout;
        req = 4'b0010;
        tick();
        req = 4'b0000;
        repeat (TO) tick();
        checks++;
        if (busy !== 1'b1 || done !== 4'b0000 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL to_early got busy=%b done=%b te=%b want 1 0000 0", busy, done, timeout_err);
        end
        tick();
        checks++;
        if (done !== 4'b0010 || timeout_err !== 1'b1 || rx_byte !== 8'hFF || m_cs_n !== 4'b1111) begin
            errors++;
            $display("FAIL to_abort got done=%b te=%b rx=%h cs=%b want 0010 1 ff 1111",
                     done, timeout_err, rx_byte, m_cs_n);
        end
        tick();
        checks++;
        if (timeout_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL to_clear got te=%b busy=%b want 0 0", timeout_err, busy);
        end
        req = 4'b0100;
        tick();
        req = 4'b0000;
        repeat (TO - 1) tick();
        m_done    = 1'b1;
        m_rx_byte = 8'h5A;
        tick();
        m_done = 1'b0;
        checks++;
        if (done !== 4'b0100 || timeout_err !== 1'b0 || rx_byte !== 8'h5A) begin
            errors++;
            $display("FAIL to_race got done=%b te=%b rx=%h want 0100 0 5a", done, timeout_err, rx_byte);
        end
        tick();
    endtask
`endif

    initial begin
        reset     = 1'b1;
        req       = 4'b0000;
        tx_byte   = {8'h44, 8'h33, 8'hA5, 8'h11};
        m_done    = 1'b0;
        m_rx_byte = 8'h00;
        test_reset();
        test_basic();
        test_round_robin();
        test_pointer_and_withdraw();
        test_mdone_idle();
        test_reset_mid_wait();
`ifdef SPI_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
